// File: rtl/johnson_counter_if.sv
// Control and status bundle for the Johnson counter: step/load requests from the
// master, counter state and decoded status back from the counter.
interface johnson_counter_if #(
   parameter int WIDTH = 4
) ();
   localparam int IDX_W = $clog2(2 * WIDTH);

   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [IDX_W-1:0] state_idx;
   logic             wrap;
   logic             illegal;

   modport master (
      output en, dir, load, load_val,
      input  q, state_idx, wrap, illegal
   );

   modport slave (
      input  en, dir, load, load_val,
      output q, state_idx, wrap, illegal
   );
endinterface

// File: rtl/johnson_counter.sv
// Twisted-ring counter with direction control, parallel load, decoded position,
// registered wrap pulse and illegal-code self-correction.
module johnson_counter #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   johnson_counter_if.slave bus
);
   localparam int               IDX_W    = $clog2(2 * WIDTH);
   localparam int               SEQ_LEN  = 2 * WIDTH;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] TOP_CODE = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             illegal;
   logic [IDX_W-1:0] idx;
   int               ones;

   // A legal code is a run of ones anchored at bit 0, or its complement.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] nv;
      nv = ~v;
      return ((v & (v + ONE)) == '0) || ((nv & (nv + ONE)) == '0);
   endfunction

   function automatic int popcount(input logic [WIDTH-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) n = n + 1;
      end
      return n;
   endfunction

   always_comb begin
      illegal = !is_legal(q_q);
      ones    = popcount(q_q);
      idx     = '0;
      if (!illegal) begin
         if (q_q[0] || (q_q == '0)) idx = IDX_W'(ones);
         else                       idx = IDX_W'(SEQ_LEN - ones);
      end
   end

   // Wrap is flagged only for genuine steps across the 2*WIDTH-1 <-> 0 boundary.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         q_d = bus.load_val;
      end else if (bus.en) begin
         if (illegal) begin
            q_d = '0;
         end else if (bus.dir) begin
            q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            wrap_d = (q_q == TOP_CODE);
         end else begin
            q_d    = {~q_q[0], q_q[WIDTH-1:1]};
            wrap_d = (q_q == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.q         = q_q;
   assign bus.state_idx = idx;
   assign bus.wrap      = wrap_q;
   assign bus.illegal   = illegal;
endmodule

// File: tb/tb_johnson_counter.sv
// Directed bench for the 4-bit Johnson counter: one task per scenario, inline checks.
module tb_johnson_counter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;

   logic [3:0] up_seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

   johnson_counter_if #(.WIDTH(4)) bus ();

   johnson_counter #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.en = 1'b1; bus.dir = 1'b1; bus.load = 1'b0; bus.load_val = 4'b0000;
      #3;
      total++; if (bus.q !== 4'b0000) $display("FAIL reset_q got=%b exp=0000", bus.q); else passed++;
      total++; if (bus.wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", bus.wrap); else passed++;
      total++; if (bus.state_idx !== 3'd0) $display("FAIL reset_idx got=%0d exp=0", bus.state_idx); else passed++;
      total++; if (bus.illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", bus.illegal); else passed++;
      #9 rst_n = 1'b1;
   endtask

   task automatic test_up();
      for (int i = 1; i <= 9; i++) begin
         tick();
         total++;
         if (bus.q !== up_seq[i % 8]) $display("FAIL up_q step=%0d got=%b exp=%b", i, bus.q, up_seq[i % 8]);
         else passed++;
         total++;
         if (bus.state_idx !== 3'(i % 8)) $display("FAIL up_idx step=%0d got=%0d exp=%0d", i, bus.state_idx, i % 8);
         else passed++;
         total++;
         if (bus.wrap !== (i == 8)) $display("FAIL up_wrap step=%0d got=%b exp=%b", i, bus.wrap, (i == 8));
         else passed++;
      end
   endtask

   task automatic test_down();
      bus.load = 1'b1; bus.load_val = 4'b0000; bus.en = 1'b0;
      tick();
      total++; if (bus.q !== 4'b0000) $display("FAIL down_load_q got=%b exp=0000", bus.q); else passed++;
      bus.load = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         total++;
         if (bus.q !== up_seq[(8 - j) % 8]) $display("FAIL down_q step=%0d got=%b exp=%b", j, bus.q, up_seq[(8 - j) % 8]);
         else passed++;
         total++;
         if (bus.state_idx !== 3'((8 - j) % 8)) $display("FAIL down_idx step=%0d got=%0d exp=%0d", j, bus.state_idx, (8 - j) % 8);
         else passed++;
         total++;
         if (bus.wrap !== (j == 1)) $display("FAIL down_wrap step=%0d got=%b exp=%b", j, bus.wrap, (j == 1));
         else passed++;
      end
      bus.en = 1'b0;
      tick();
      total++; if (bus.wrap !== 1'b0) $display("FAIL hold_wrap got=%b exp=0", bus.wrap); else passed++;
   endtask

   task automatic test_illegal();
      bus.load = 1'b1; bus.load_val = 4'b0101; bus.en = 1'b0;
      tick();
      total++; if (bus.q !== 4'b0101) $display("FAIL ill_load_q got=%b exp=0101", bus.q); else passed++;
      total++; if (bus.illegal !== 1'b1) $display("FAIL ill_flag got=%b exp=1", bus.illegal); else passed++;
      total++; if (bus.state_idx !== 3'd0) $display("FAIL ill_idx got=%0d exp=0", bus.state_idx); else passed++;
      bus.load = 1'b0;
      tick();
      total++; if (bus.q !== 4'b0101) $display("FAIL ill_hold_q got=%b exp=0101", bus.q); else passed++;
      bus.en = 1'b1; bus.dir = 1'b1;
      tick();
      total++; if (bus.q !== 4'b0000) $display("FAIL ill_fix_q got=%b exp=0000", bus.q); else passed++;
      total++; if (bus.illegal !== 1'b0) $display("FAIL ill_fix_flag got=%b exp=0", bus.illegal); else passed++;
      total++; if (bus.wrap !== 1'b0) $display("FAIL ill_fix_wrap got=%b exp=0", bus.wrap); else passed++;
      bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'b1100;
      tick();
      total++; if (bus.state_idx !== 3'd6) $display("FAIL idx_1100 got=%0d exp=6", bus.state_idx); else passed++;
      total++; if (bus.illegal !== 1'b0) $display("FAIL legal_1100 got=%b exp=0", bus.illegal); else passed++;
      bus.load_val = 4'b1001;
      tick();
      total++; if (bus.illegal !== 1'b1) $display("FAIL illegal_1001 got=%b exp=1", bus.illegal); else passed++;
      bus.load_val = 4'b0110;
      tick();
      total++; if (bus.illegal !== 1'b1) $display("FAIL illegal_0110 got=%b exp=1", bus.illegal); else passed++;
      bus.load = 1'b0;
   endtask

   task automatic test_load_priority();
      bus.load = 1'b1; bus.en = 1'b1; bus.dir = 1'b1; bus.load_val = 4'b0111;
      tick();
      total++; if (bus.q !== 4'b0111) $display("FAIL prio_q got=%b exp=0111", bus.q); else passed++;
      bus.load = 1'b0; bus.en = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      total++; if (bus.q !== 4'b0111) $display("FAIL prio_hold_q got=%b exp=0111", bus.q); else passed++;
      total++; if (bus.state_idx !== 3'd3) $display("FAIL prio_idx got=%0d exp=3", bus.state_idx); else passed++;
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.q !== 4'b0000) $display("FAIL areset_q got=%b exp=0000", bus.q); else passed++;
      total++; if (bus.wrap !== 1'b0) $display("FAIL areset_wrap got=%b exp=0", bus.wrap); else passed++;
      @(negedge clk) rst_n = 1'b1;
      bus.load = 1'b1; bus.load_val = 4'b1000;
      tick();
      bus.load = 1'b0; bus.en = 1'b1; bus.dir = 1'b1;
      tick();
      total++; if (bus.wrap !== 1'b1) $display("FAIL pre_areset_wrap got=%b exp=1", bus.wrap); else passed++;
      bus.en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.wrap !== 1'b0) $display("FAIL areset_wrap2 got=%b exp=0", bus.wrap); else passed++;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_dir_change();
      bus.load = 1'b1; bus.load_val = 4'b1111; bus.en = 1'b0;
      tick();
      bus.load = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
      tick();
      total++; if (bus.q !== 4'b0111) $display("FAIL dir_q1 got=%b exp=0111", bus.q); else passed++;
      tick();
      total++; if (bus.q !== 4'b0011) $display("FAIL dir_q2 got=%b exp=0011", bus.q); else passed++;
      bus.dir = 1'b1;
      tick();
      total++; if (bus.q !== 4'b0111) $display("FAIL dir_q3 got=%b exp=0111", bus.q); else passed++;
      total++; if (bus.state_idx !== 3'd3) $display("FAIL dir_idx got=%0d exp=3", bus.state_idx); else passed++;
      bus.en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up();
      test_down();
      test_illegal();
      test_load_priority();
      test_async_reset();
      test_dir_change();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
